// File: rtl/capture_store_fifo_pkg.sv
// Shared definitions for the capture/store FIFO: c_enable encodings, FSM states, defaults.
package capture_store_fifo_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic [7:0] CE_COUNT = 8'd0;
  localparam logic [7:0] CE_STORE = 8'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/capture_store_fifo_if.sv
// Stream/status bundle between the count/store stage, the capture FIFO and its consumer.
interface capture_store_fifo_if
  import capture_store_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = 3
);

  logic [7:0]        c_enable;
  logic [DATA_W-1:0] store;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   level;
  logic              full;
  logic [7:0]        ovf_cnt;
  logic              ovf_clr;

  // Master drives the capture inputs and consumes the stream; slave is the capture FIFO.
  modport master (
    output c_enable,
    output store,
    output out_ready,
    output ovf_clr,
    input  out_data,
    input  out_valid,
    input  level,
    input  full,
    input  ovf_cnt
  );

  modport slave (
    input  c_enable,
    input  store,
    input  out_ready,
    input  ovf_clr,
    output out_data,
    output out_valid,
    output level,
    output full,
    output ovf_cnt
  );

endinterface

// File: rtl/capture_store_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO; push while full is accepted only alongside a pop.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W:0]   o_level,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;

  logic w_full;
  logic w_empty;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_full     = (r_level == (ADDR_W+1)'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_pop_acc  = i_pop & ~w_empty;
  assign w_push_acc = i_push & (~w_full | w_pop_acc);

  // Storage carries no reset; pointer reset is enough to discard contents.
  always_ff @(posedge i_clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/capture_store_fifo.sv
// Detects count->store transitions on c_enable, queues each captured value and streams it out.
module capture_store_fifo
  import capture_store_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  newclk_k,
  input  logic                  rst,
  capture_store_fifo_if.slave   cap_bus
);

  cap_state_e        r_state;
  logic              r_wr_req;
  logic [7:0]        r_ovf_cnt;

  logic [DATA_W-1:0] w_rdata;
  logic [ADDR_W:0]   w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  // r_wr_req is high exactly while in CAPT, so the edge leaving CAPT writes store.
  always_ff @(posedge newclk_k or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_req <= 1'b0;
    end else begin
      r_wr_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cap_bus.c_enable == CE_COUNT) r_state <= COUNT;
        end
        COUNT: begin
          if (cap_bus.c_enable == CE_STORE) begin
            r_state  <= CAPT;
            r_wr_req <= 1'b1;
          end else if (cap_bus.c_enable != CE_COUNT) begin
            r_state <= IDLE;
          end
        end
        CAPT: begin
          if (cap_bus.c_enable == CE_STORE)      r_state <= HOLD;
          else if (cap_bus.c_enable == CE_COUNT) r_state <= COUNT;
          else                                   r_state <= IDLE;
        end
        HOLD: begin
          if (cap_bus.c_enable == CE_COUNT)      r_state <= COUNT;
          else if (cap_bus.c_enable != CE_STORE) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_pop  = ~w_empty & cap_bus.out_ready;
  assign w_drop = r_wr_req & w_full & ~w_pop;

  always_ff @(posedge newclk_k or posedge rst) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (cap_bus.ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk   (newclk_k),
    .i_rst   (rst),
    .i_push  (r_wr_req),
    .i_pop   (cap_bus.out_ready),
    .i_wdata (cap_bus.store),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cap_bus.out_data  = w_rdata;
  assign cap_bus.out_valid = ~w_empty;
  assign cap_bus.level     = w_level;
  assign cap_bus.full      = w_full;
  assign cap_bus.ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_capture_store_fifo.sv
// Scenario bench for capture_store_fifo with a queue scoreboard of expected FIFO contents.
module tb_capture_store_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic clk;
  logic rst;

  capture_store_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cap_if ();

  capture_store_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .newclk_k (clk),
    .rst      (rst),
    .cap_bus  (cap_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  int exp_ovf = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change only at negedge; checks also happen at negedge, away from the rising edge.
  task automatic capture(input logic [DATA_W-1:0] v, input bit ready_on_write, input bit clr);
    bit pop;
    bit was_full;
    cap_if.c_enable = 8'd0;
    @(negedge clk);
    cap_if.c_enable = 8'd1;
    @(negedge clk);
    cap_if.store     = v;
    cap_if.out_ready = ready_on_write;
    cap_if.ovf_clr   = clr;
    was_full = (exp_q.size() == DEPTH);
    pop      = ready_on_write && (exp_q.size() > 0);
    if (pop) begin
      n_tests++;
      if (cap_if.out_valid !== 1'b1 || cap_if.out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL pop_on_write: got v=%0b d=%0h expected v=1 d=%0h",
                 cap_if.out_valid, cap_if.out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    if (!was_full || pop) exp_q.push_back(v);
    if (clr) exp_ovf = 0;
    else if (was_full && !pop && exp_ovf < 255) exp_ovf++;
    @(negedge clk);
    cap_if.out_ready = 1'b0;
    cap_if.ovf_clr   = 1'b0;
  endtask

  task automatic drain(input string name);
    cap_if.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1 && exp_q.size() > 0; i++) begin
      n_tests++;
      if (cap_if.out_valid !== 1'b1 || cap_if.out_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL %s_data: got v=%0b d=%0h expected v=1 d=%0h",
                 name, cap_if.out_valid, cap_if.out_data, exp_q[0]);
      end
      n_tests++;
      if (cap_if.level !== (ADDR_W+1)'(exp_q.size())) begin
        n_fail++;
        $display("FAIL %s_level: got %0d expected %0d", name, cap_if.level, exp_q.size());
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    cap_if.out_ready = 1'b0;
    n_tests++;
    if (cap_if.out_valid !== 1'b0 || cap_if.level !== '0) begin
      n_fail++;
      $display("FAIL %s_empty: got v=%0b lvl=%0d expected v=0 lvl=0",
               name, cap_if.out_valid, cap_if.level);
    end
  endtask

  task automatic check_status(input string name);
    n_tests++;
    if (cap_if.level !== (ADDR_W+1)'(exp_q.size()) || cap_if.ovf_cnt !== 8'(exp_ovf) ||
        cap_if.full !== (exp_q.size() == DEPTH) || cap_if.out_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL %s: got lvl=%0d ovf=%0d full=%0b v=%0b expected lvl=%0d ovf=%0d full=%0b v=%0b",
               name, cap_if.level, cap_if.ovf_cnt, cap_if.full, cap_if.out_valid,
               exp_q.size(), exp_ovf, exp_q.size() == DEPTH, exp_q.size() != 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cap_if.c_enable  = 8'd5;
    cap_if.store     = '0;
    cap_if.out_ready = 1'b0;
    cap_if.ovf_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    check_status("reset");
  endtask

  task automatic test_idle();
    bit bad = 0;
    cap_if.c_enable = 8'd5;
    repeat (20) begin
      @(negedge clk);
      if (cap_if.out_valid !== 1'b0 || cap_if.level !== '0 || cap_if.ovf_cnt !== '0) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL idle_hold: got activity expected none");
    end
    // 1 arriving straight from IDLE must not capture
    cap_if.c_enable = 8'd1;
    repeat (5) @(negedge clk);
    check_status("idle_store_no_capture");
    cap_if.c_enable = 8'd5;
    @(negedge clk);
  endtask

  task automatic test_single_capture();
    cap_if.c_enable = 8'd0;
    repeat (3) @(negedge clk);
    cap_if.c_enable = 8'd1;
    @(negedge clk);
    cap_if.store = 8'h2A;
    n_tests++;
    if (cap_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_in_capt: got v=%0b expected v=0", cap_if.out_valid);
    end
    exp_q.push_back(8'h2A);
    @(negedge clk);
    n_tests++;
    if (cap_if.out_valid !== 1'b1 || cap_if.out_data !== 8'h2A || cap_if.level !== 4'd1) begin
      n_fail++;
      $display("FAIL single_written: got v=%0b d=%0h lvl=%0d expected v=1 d=2a lvl=1",
               cap_if.out_valid, cap_if.out_data, cap_if.level);
    end
    repeat (2) @(negedge clk);
    check_status("single_no_recapture");
    drain("single_drain");
  endtask

  task automatic test_stream_drain();
    capture(8'd10, 1'b0, 1'b0);
    capture(8'd20, 1'b0, 1'b0);
    capture(8'd30, 1'b0, 1'b0);
    check_status("stream_fill");
    drain("stream");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) capture(8'(i), 1'b0, 1'b0);
    check_status("ovf_full");
    n_tests++;
    if (cap_if.ovf_cnt !== 8'd2 || cap_if.full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_count: got ovf=%0d full=%0b expected ovf=2 full=1",
               cap_if.ovf_cnt, cap_if.full);
    end
    drain("ovf_drain");
  endtask

  task automatic test_push_pop_full();
    int ovf_before;
    for (int i = 0; i < DEPTH; i++) capture(8'(50 + i), 1'b0, 1'b0);
    ovf_before = exp_ovf;
    capture(8'd99, 1'b1, 1'b0);
    check_status("pushpop_full");
    n_tests++;
    if (cap_if.ovf_cnt !== 8'(ovf_before) || exp_q[DEPTH-1] !== 8'd99) begin
      n_fail++;
      $display("FAIL pushpop_ovf: got %0d expected %0d", cap_if.ovf_cnt, ovf_before);
    end
    drain("pushpop_drain");
  endtask

  task automatic test_reset_mid_capt();
    capture(8'h11, 1'b0, 1'b0);
    check_status("rmc_pre");
    cap_if.c_enable = 8'd0;
    @(negedge clk);
    cap_if.c_enable = 8'd1;
    @(negedge clk);
    cap_if.store = 8'h77;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    check_status("rmc_after");
    repeat (3) @(negedge clk);
    check_status("rmc_settled");
  endtask

  task automatic test_ovf_saturate_clr();
    for (int i = 0; i < DEPTH + 260; i++) capture(8'(i), 1'b0, 1'b0);
    check_status("sat_255");
    n_tests++;
    if (cap_if.ovf_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_value: got %0d expected 255", cap_if.ovf_cnt);
    end
    capture(8'hEE, 1'b0, 1'b1);
    check_status("clr_wins");
    capture(8'hEF, 1'b0, 1'b0);
    check_status("after_clr_inc");
    drain("sat_drain");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_idle();
    test_single_capture();
    test_stream_drain();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_capt();
    test_ovf_saturate_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
